// File: rtl/grs_round_arb.sv
// rtl/grs_round_arb.sv - round-robin arbiter sharing one GRS rounding unit; GRS_ARB_INEXACT_EN adds out_inexact
// grs_round: drops SHIFT low bits and applies the rounding increment selected by mode.
module grs_round #(
    parameter int INPUT_WIDTH  = 28,
    parameter int OUTPUT_WIDTH = 24
) (
    input  logic [INPUT_WIDTH-1:0]  value,
    input  logic                    sign,
    input  logic [2:0]              mode,
    output logic [OUTPUT_WIDTH-1:0] result,
    output logic                    carry
);
    localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;
    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RPI = 3'd2;
    localparam logic [2:0] RNI = 3'd3;
    localparam logic [2:0] RNA = 3'd4;

    logic increment;

    generate
        if (SHIFT == 0) begin : g_exact
            logic unused_ctl;
            assign unused_ctl = ^{sign, mode};
            assign increment  = 1'b0;
        end else begin : g_round
            logic lsb, guard, sticky;
            assign lsb   = value[SHIFT];
            assign guard = value[SHIFT-1];
            if (SHIFT == 1) begin : g_no_sticky
                assign sticky = 1'b0;
            end else begin : g_sticky
                assign sticky = |value[SHIFT-2:0];
            end
            always_comb begin
                increment = 1'b0;
                case (mode)
                    RNE:     increment = guard & (sticky | lsb);
                    RTZ:     increment = 1'b0;
                    RPI:     increment = (guard | sticky) & ~sign;
                    RNI:     increment = (guard | sticky) & sign;
                    RNA:     increment = guard;
                    default: increment = 1'b0;
                endcase
            end
        end
    endgenerate

    assign {carry, result} = {1'b0, value[INPUT_WIDTH-1:SHIFT]} + {{OUTPUT_WIDTH{1'b0}}, increment};
endmodule

module grs_round_arb #(
    parameter  int NUM_REQ      = 4,
    parameter  int INPUT_WIDTH  = 28,
    parameter  int OUTPUT_WIDTH = 24,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_value,
    input  logic [NUM_REQ-1:0]             req_sign,
    input  logic [NUM_REQ*3-1:0]           req_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUTPUT_WIDTH-1:0]        out_value,
    output logic                           out_carry,
    output logic                           out_sign,
    output logic [ID_W-1:0]                out_id
`ifdef GRS_ARB_INEXACT_EN
    ,
    output logic                           out_inexact
`endif
);
    localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;

    generate
        if (INPUT_WIDTH < OUTPUT_WIDTH) begin : g_bad_width
            $error("grs_round_arb: INPUT_WIDTH must be >= OUTPUT_WIDTH");
        end
        if (NUM_REQ < 2) begin : g_bad_num
            $error("grs_round_arb: NUM_REQ must be >= 2");
        end
    endgenerate

    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         gnt_idx;
    logic [ID_W-1:0]         scan_idx;
    logic                    gnt_any;
    logic                    load;
    logic                    accept;
    logic [INPUT_WIDTH-1:0]  gnt_value;
    logic [2:0]              gnt_mode;
    logic                    gnt_sign;
    logic [OUTPUT_WIDTH-1:0] rnd_value;
    logic                    rnd_carry;

    // Scan from the highest offset down so the nearest valid requester after rr_ptr wins.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign load      = ~out_valid | out_ready;
    assign accept    = gnt_any & load & ~rst;
    assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

    assign gnt_value = req_value[int'(gnt_idx)*INPUT_WIDTH +: INPUT_WIDTH];
    assign gnt_mode  = req_mode[int'(gnt_idx)*3 +: 3];
    assign gnt_sign  = req_sign[gnt_idx];

    grs_round #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) u_round (
        .value (gnt_value),
        .sign  (gnt_sign),
        .mode  (gnt_mode),
        .result(rnd_value),
        .carry (rnd_carry)
    );

`ifdef GRS_ARB_INEXACT_EN
    logic gnt_inexact;
    generate
        if (SHIFT == 0) begin : g_inexact_none
            assign gnt_inexact = 1'b0;
        end else begin : g_inexact
            assign gnt_inexact = |gnt_value[SHIFT-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            out_inexact <= 1'b0;
        else if (accept)
            out_inexact <= gnt_inexact;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_carry <= 1'b0;
            out_sign  <= 1'b0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_value <= rnd_value;
                out_carry <= rnd_carry;
                out_sign  <= gnt_sign;
                out_id    <= gnt_idx;
                rr_ptr    <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_grs_round_arb.sv
// tb/tb_grs_round_arb.sv - directed and randomized bench for grs_round_arb against an arithmetic reference model
module tb_grs_round_arb;
    localparam int N  = 4;
    localparam int IW = 28;
    localparam int OW = 24;
    localparam int SH = IW - OW;
    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RPI = 3'd2;
    localparam logic [2:0] RNI = 3'd3;
    localparam logic [2:0] RNA = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready, req_sign;
    logic [N*IW-1:0] req_value;
    logic [N*3-1:0]  req_mode;
    logic            out_valid, out_ready, out_carry, out_sign;
    logic [OW-1:0]   out_value;
    logic [1:0]      out_id;
`ifdef GRS_ARB_INEXACT_EN
    logic            out_inexact;
`endif

    grs_round_arb #(.NUM_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_value(req_value),
        .req_sign(req_sign), .req_mode(req_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_carry(out_carry), .out_sign(out_sign), .out_id(out_id)
`ifdef GRS_ARB_INEXACT_EN
        , .out_inexact(out_inexact)
`endif
    );

    int errors = 0;
    int checks = 0;

    bit            rv[N];
    logic [IW-1:0] rval[N];
    bit            rs[N];
    logic [2:0]    rm[N];
    bit            o_ready;
    bit            hold_valid;

    bit            m_valid, m_carry, m_sign, m_inexact;
    logic [OW-1:0] m_value;
    int            m_id, m_ptr, last_acc;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rounding computed from the integer quotient/remainder of value / 2^SH.
    task automatic model_round(input logic [IW-1:0] v, input bit s, input logic [2:0] md);
        longint up, sum;
        int rem, half;
        bit inc;
        up   = longint'(v) >> SH;
        rem  = int'(v) % (1 << SH);
        half = 1 << (SH - 1);
        case (md)
            RNE:     inc = (rem > half) || (rem == half && (up % 2) == 1);
            RTZ:     inc = 0;
            RPI:     inc = (rem != 0) && !s;
            RNI:     inc = (rem != 0) && s;
            RNA:     inc = rem >= half;
            default: inc = 0;
        endcase
        sum       = up + longint'(inc);
        m_value   = OW'(sum % (longint'(1) << OW));
        m_carry   = sum >= (longint'(1) << OW);
        m_inexact = rem != 0;
    endtask

    task automatic step();
        int g;
        bit ld;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = rv[i];
            req_value[i*IW +: IW]  = rval[i];
            req_sign[i]            = rs[i];
            req_mode[i*3 +: 3]     = rm[i];
        end
        out_ready = o_ready;
        @(negedge clk);
        ld = !m_valid || o_ready;
        g  = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        er = (!rst && ld && g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        last_acc = -1;
        if (rst) begin
            m_valid = 0; m_value = '0; m_carry = 0; m_sign = 0; m_id = 0; m_inexact = 0; m_ptr = 0;
        end else if (ld) begin
            if (g >= 0) begin
                model_round(rval[g], rs[g], rm[g]);
                m_sign   = rs[g];
                m_id     = g;
                m_valid  = 1;
                m_ptr    = (g + 1) % N;
                last_acc = g;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_value", 32'(out_value), 32'(m_value));
        chk("out_carry", 32'(out_carry), 32'(m_carry));
        chk("out_sign",  32'(out_sign),  32'(m_sign));
        chk("out_id",    32'(out_id),    32'(m_id));
`ifdef GRS_ARB_INEXACT_EN
        chk("out_inexact", 32'(out_inexact), 32'(m_inexact));
`endif
        if (!hold_valid && last_acc >= 0) rv[last_acc] = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rv[i] = 0; rval[i] = '0; rs[i] = 0; rm[i] = RNE;
        end
        o_ready = 1; hold_valid = 0; rst = 1;
        m_valid = 0; m_value = '0; m_carry = 0; m_sign = 0; m_id = 0; m_inexact = 0; m_ptr = 0;
        step();
        step();
        rst = 0;

        rv[0] = 1; rval[0] = 28'h0000018; rm[0] = RNE;
        step();
        chk("t1_value", 32'(out_value), 32'h000002);
        chk("t1_id", 32'(out_id), 32'd0);
`ifdef GRS_ARB_INEXACT_EN
        chk("t1_inexact", 32'(out_inexact), 32'd1);
`endif
        step();
        chk("t1_drain", 32'(out_valid), 32'd0);

        rv[1] = 1; rval[1] = 28'h0000028; rm[1] = RNE;
        step();
        chk("t2_rne", 32'(out_value), 32'h000002);
        chk("t2_id", 32'(out_id), 32'd1);
        rv[1] = 1; rm[1] = RNA;
        step();
        chk("t2_rna", 32'(out_value), 32'h000003);

        rv[2] = 1; rval[2] = 28'hFFFFFF8; rm[2] = RNA;
        step();
        chk("t3_value", 32'(out_value), 32'h000000);
        chk("t3_carry", 32'(out_carry), 32'd1);
        rv[2] = 1; rm[2] = RTZ;
        step();
        chk("t3_rtz", 32'(out_value), 32'hFFFFFF);
        chk("t3_rtz_carry", 32'(out_carry), 32'd0);

        rv[3] = 1; rval[3] = 28'h0000020; rm[3] = RNE;
        step();
        chk("t3b_value", 32'(out_value), 32'h000002);
`ifdef GRS_ARB_INEXACT_EN
        chk("t3b_inexact", 32'(out_inexact), 32'd0);
`endif

        rst = 1;
        step();
        rst = 0;
        hold_valid = 1;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1; rval[i] = IW'($urandom); rs[i] = 1'($urandom); rm[i] = 3'($urandom_range(0, 4));
        end
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_rr_id", 32'(out_id), 32'(k % N));
        end

        o_ready = 0;
        repeat (5) step();
        o_ready = 1;
        step();
        chk("t5_resume_id", 32'(out_id), 32'd1);

        o_ready = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        rv[0] = 0;
        o_ready = 1;
        step();
        chk("t6_lowest_id", 32'(out_id), 32'd1);
        hold_valid = 0;

        for (int n = 0; n < 400; n++) begin
            o_ready = $urandom_range(0, 3) != 0;
            rst     = $urandom_range(0, 60) == 0;
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i]   = 1;
                    rs[i]   = 1'($urandom);
                    rm[i]   = 3'($urandom_range(0, 7));
                    rval[i] = ($urandom_range(0, 3) == 0) ? {24'hFFFFFF, 4'($urandom)} : IW'($urandom);
                end
            end
            step();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
